// File: rtl/gun_ctrl.sv
// gun_ctrl: maps mouse bins to screen coordinates and fires single, burst or auto
// shots from a magazine with manual and automatic reload.
module gun_ctrl #(
   parameter int BIN_W        = 6,
   parameter int BIN_SIZE     = 10,
   parameter int MAX_H        = 480,
   parameter int CD_TICKS     = 19_999_999,
   parameter int BURST_LEN    = 3,
   parameter int BURST_GAP    = 4_999_999,
   parameter int MAG_SIZE     = 12,
   parameter int RELOAD_TICKS = 49_999_999
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [1:0]                    mode,
   input  logic [BIN_W-1:0]              bin_x,
   input  logic [BIN_W-1:0]              bin_y,
   input  logic                          button_left,
   input  logic                          button_right,
   output logic [9:0]                    shoot_x,
   output logic [8:0]                    shoot_y,
   output logic                          shot,
   output logic [$clog2(MAG_SIZE+1)-1:0] ammo,
   output logic                          reloading,
   output logic                          busy
);
   localparam int AW = $clog2(MAG_SIZE + 1);
   localparam int RW = $clog2(BURST_LEN + 1);
   typedef enum logic [1:0] {S_IDLE, S_GAP, S_CD, S_RELOAD} state_t;
   state_t        state, nxt;
   logic [31:0]   cnt, cnt_n, take;
   logic [RW-1:0] rem, rem_n;
   logic          left_q, left_rise, trig, fire, refill;
   logic [9:0]    cx;
   logic [8:0]    cy;
   assign cx        = 10'(bin_x * BIN_SIZE);
   assign cy        = 9'(MAX_H) - 9'(bin_y * BIN_SIZE);
   assign left_rise = button_left & ~left_q;
   assign trig      = (mode == 2'd2) ? button_left : left_rise;
   assign take      = (32'(ammo) < 32'(BURST_LEN)) ? 32'(ammo) : 32'(BURST_LEN);
   assign busy      = state != S_IDLE;
   assign reloading = state == S_RELOAD;
   always_comb begin
      nxt    = state;
      cnt_n  = cnt;
      rem_n  = rem;
      fire   = 1'b0;
      refill = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (ammo == '0 || (button_right && ammo < AW'(MAG_SIZE))) nxt = S_RELOAD;
            else if (trig) begin
               fire  = 1'b1;
               rem_n = RW'(take - 32'd1);
               // burst shortens itself when the magazine holds fewer rounds than a burst
               nxt   = (mode == 2'd1 && take > 32'd1) ? S_GAP : S_CD;
            end
         end
         S_GAP: begin
            fire  = cnt == 32'(BURST_GAP - 1);
            cnt_n = fire ? '0 : cnt + 32'd1;
            rem_n = fire ? rem - RW'(1) : rem;
            nxt   = (fire && rem == RW'(1)) ? S_CD : S_GAP;
         end
         S_CD: begin
            nxt   = (cnt == 32'(CD_TICKS - 1)) ? S_IDLE : S_CD;
            cnt_n = (cnt == 32'(CD_TICKS - 1)) ? '0 : cnt + 32'd1;
         end
         default: begin
            refill = cnt == 32'(RELOAD_TICKS - 1);
            nxt    = refill ? S_IDLE : S_RELOAD;
            cnt_n  = refill ? '0 : cnt + 32'd1;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rem     <= '0;
         left_q  <= 1'b0;
         ammo    <= AW'(MAG_SIZE);
         shot    <= 1'b0;
         shoot_x <= '0;
         shoot_y <= '0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_n;
         rem    <= rem_n;
         left_q <= button_left;
         shot   <= fire;
         ammo   <= refill ? AW'(MAG_SIZE) : fire ? ammo - AW'(1) : ammo;
         if (fire) begin
            shoot_x <= cx;
            shoot_y <= cy;
         end
      end
   end
endmodule

// File: tb/tb_gun_ctrl.sv
// tb_gun_ctrl: scoreboard bench; expected shots are queued as stimulus is driven
// and matched against every shot pulse the DUT emits.
module tb_gun_ctrl;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [5:0] bin_x = 6'd6;
   logic [5:0] bin_y = 6'd9;
   logic       button_left = 1'b0;
   logic       button_right = 1'b0;
   logic [9:0] shoot_x;
   logic [8:0] shoot_y;
   logic       shot;
   logic [2:0] ammo;
   logic       reloading;
   logic       busy;
   typedef struct {int cyc; int x; int y; int a;} exp_t;
   exp_t q[$];
   int cyc = 0;
   int n_chk = 0;
   int n_bad = 0;
   int c0;
   gun_ctrl #(.CD_TICKS(4), .BURST_LEN(3), .BURST_GAP(2), .MAG_SIZE(5), .RELOAD_TICKS(6)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .bin_x(bin_x), .bin_y(bin_y),
      .button_left(button_left), .button_right(button_right), .shoot_x(shoot_x),
      .shoot_y(shoot_y), .shot(shot), .ammo(ammo), .reloading(reloading), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic push(input int c, input int y, input int a);
      exp_t e;
      e.cyc = c;
      e.x = 60;
      e.y = y;
      e.a = a;
      q.push_back(e);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      button_left = 1'b0;
      button_right = 1'b0;
      bin_y = 6'd9;
      q.delete();
      #1;
      chk("rst_ammo", ammo, 5);
      chk("rst_shot", shot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sx", shoot_x, 0);
      chk("rst_sy", shoot_y, 0);
      tick(2);
      reset_n = 1'b1;
   endtask
   always @(negedge clk) begin
      if (shot) begin
         if (q.size() == 0) chk("shot_extra", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("shot_cyc", cyc, e.cyc);
            chk("shot_x", shoot_x, e.x);
            chk("shot_y", shoot_y, e.y);
            chk("shot_ammo", ammo, e.a);
         end
      end
   end
   initial begin
      // single: one shot per press, no refire while held, y wraps for large bins
      do_reset();
      mode = 2'd0;
      button_left = 1'b1;
      c0 = cyc;
      push(c0 + 1, 390, 4);
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (i <= 5) chk("t1_busy", busy, (i <= 4) ? 1 : 0);
      end
      chk("t1_ammo", ammo, 4);
      button_left = 1'b0;
      tick(1);
      bin_y = 6'd50;
      button_left = 1'b1;
      push(cyc + 1, 492, 3);
      tick(1);
      button_left = 1'b0;
      tick(6);
      chk("t1_ammo2", ammo, 3);
      chk("t1_q", q.size(), 0);
      // burst of three
      do_reset();
      mode = 2'd1;
      button_left = 1'b1;
      c0 = cyc;
      push(c0 + 1, 390, 4);
      push(c0 + 3, 390, 3);
      push(c0 + 5, 390, 2);
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         button_left = 1'b0;
         chk("t2_busy", busy, (i < 9) ? 1 : 0);
      end
      chk("t2_ammo", ammo, 2);
      chk("t2_q", q.size(), 0);
      // auto until empty, then automatic reload
      do_reset();
      mode = 2'd2;
      button_left = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 5; k++) push(c0 + 1 + 5 * k, 390, 4 - k);
      for (int i = 1; i <= 32; i++) begin
         tick(1);
         if (i == 31) button_left = 1'b0;
         chk("t3_rel", reloading, (i >= 26 && i <= 31) ? 1 : 0);
         if (i == 21) chk("t3_empty", ammo, 0);
      end
      chk("t3_ammo", ammo, 5);
      tick(3);
      chk("t3_q", q.size(), 0);
      // burst truncated by a two-round magazine
      do_reset();
      mode = 2'd1;
      button_left = 1'b1;
      c0 = cyc;
      push(c0 + 1, 390, 4);
      push(c0 + 3, 390, 3);
      push(c0 + 5, 390, 2);
      tick(1);
      button_left = 1'b0;
      tick(11);
      chk("t4_ammo2", ammo, 2);
      button_left = 1'b1;
      c0 = cyc;
      push(c0 + 1, 390, 1);
      push(c0 + 3, 390, 0);
      for (int i = 1; i <= 14; i++) begin
         tick(1);
         button_left = 1'b0;
         chk("t4_rel", reloading, (i >= 8 && i <= 13) ? 1 : 0);
         if (i == 4) chk("t4_empty", ammo, 0);
      end
      chk("t4_ammo", ammo, 5);
      chk("t4_q", q.size(), 0);
      // reload request beats a simultaneous trigger
      do_reset();
      mode = 2'd0;
      for (int k = 0; k < 2; k++) begin
         button_left = 1'b1;
         push(cyc + 1, 390, 4 - k);
         tick(1);
         button_left = 1'b0;
         tick(6);
      end
      chk("t5_ammo3", ammo, 3);
      button_left = 1'b1;
      button_right = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         button_left = 1'b0;
         button_right = 1'b0;
         chk("t5_rel", reloading, (i <= 6) ? 1 : 0);
      end
      chk("t5_ammo", ammo, 5);
      chk("t5_q", q.size(), 0);
      // asynchronous reset mid-reload
      do_reset();
      mode = 2'd0;
      button_left = 1'b1;
      push(cyc + 1, 390, 4);
      tick(1);
      button_left = 1'b0;
      tick(6);
      button_right = 1'b1;
      tick(1);
      button_right = 1'b0;
      tick(2);
      chk("t6_inrel", reloading, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_ammo", ammo, 5);
      chk("t6_rel", reloading, 0);
      chk("t6_busy", busy, 0);
      tick(2);
      reset_n = 1'b1;
      // asynchronous reset mid-burst, on the cycle of the first pulse
      mode = 2'd1;
      button_left = 1'b1;
      push(cyc + 1, 390, 4);
      tick(1);
      button_left = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("t6b_shot", shot, 0);
      chk("t6b_busy", busy, 0);
      chk("t6b_ammo", ammo, 5);
      chk("t6b_rel", reloading, 0);
      tick(2);
      reset_n = 1'b1;
      tick(12);
      chk("t6b_ammo2", ammo, 5);
      chk("t6b_q", q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/gun_ctrl.md
Name: gun_ctrl

Overview:
Parametrised successor to the single-shot gun controller. Converts mouse bin coordinates to screen coordinates and fires in one of three modes: single, burst or automatic. Tracks a magazine with manual and automatic reload. Sits between the mouse/button interface and the hit-detection/scoring logic, and emits a registered one-cycle shot pulse with the coordinates latched at that pulse. The crosshair renderer is outside this block and is fed separately.

Parameters:
BIN_W, 6, width of bin_x/bin_y
BIN_SIZE, 10, screen pixels per mouse bin
MAX_H, 480, screen height; used for y inversion
CD_TICKS, 19_999_999, cooldown length in cycles after a single/auto shot or the end of a burst
BURST_LEN, 3, shots per burst
BURST_GAP, 4_999_999, cycles between consecutive burst shot pulses
MAG_SIZE, 12, magazine capacity
RELOAD_TICKS, 49_999_999, reload duration in cycles

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
mode  in  2  0=single, 1=burst, 2=auto, 3=treated as single
bin_x  in  BIN_W  mouse x bin
bin_y  in  BIN_W  mouse y bin (inverted axis)
button_left  in  1  trigger (level)
button_right  in  1  reload request (level)
shoot_x  out  10  latched x of last shot
shoot_y  out  9  latched y of last shot
shot  out  1  one-cycle registered shot pulse
ammo  out  $clog2(MAG_SIZE+1)  rounds remaining
reloading  out  1  high while in S_RELOAD
busy  out  1  high when state != S_IDLE

Behaviour:
- Reset (async, reset_n=0): state=S_IDLE; ammo=MAG_SIZE; shot=0; shoot_x=0; shoot_y=0; all counters and left_q=0. Takes effect immediately, with no clock edge needed, from any state.
- Coordinates, computed combinationally each cycle:
  - cx = 10'(bin_x*BIN_SIZE).
  - cy = 9'(MAX_H) - 9'(bin_y*BIN_SIZE); arithmetic is mod 2^9 (wraps).
- Edge detect: left_q <= button_left every cycle in every state; left_rise = button_left & ~left_q.
- Fire action in cycle t:
  - Next edge sets shot=1, shoot_x=cx(t), shoot_y=cy(t), ammo=ammo-1.
  - shot returns to 0 the following cycle.
  - shoot_x/shoot_y hold until the next fire.
- States: S_IDLE, S_GAP, S_CD, S_RELOAD.
- S_IDLE, evaluated in priority order:
  1. ammo==0 -> S_RELOAD.
  2. button_right & ammo<MAG_SIZE -> S_RELOAD. Reload wins over a simultaneous trigger; no shot is fired.
  3. Trigger fires:
     - single: left_rise.
     - burst: left_rise.
     - auto: button_left level.
  4. After a fire:
     - single/auto -> S_CD.
     - burst: rem = min(BURST_LEN, ammo)-1; rem>0 -> S_GAP, else S_CD.
  5. mode is sampled only at this trigger point. A mode change during a burst, cooldown or reload has no effect.
- S_GAP:
  - Counter runs 0..BURST_GAP-1; fire when counter==BURST_GAP-1, then rem-=1.
  - rem reaches 0 -> S_CD; else restart the counter in S_GAP.
  - Burst continues regardless of button_left release or button_right.
  - Burst shot-pulse spacing = BURST_GAP cycles.
- S_CD: stays exactly CD_TICKS cycles, then -> S_IDLE. Auto mode with the button held fires every CD_TICKS+1 cycles.
- S_RELOAD: stays exactly RELOAD_TICKS cycles, then ammo=MAG_SIZE and -> S_IDLE. All buttons are ignored.
- No shot is ever issued with ammo==0; ammo never underflows.
- busy and reloading are combinational from state.
- In single mode, holding the button through cooldown does not refire; release and re-press is required.

Test Plan:
Bench parameters: CD_TICKS=4, BURST_LEN=3, BURST_GAP=2, MAG_SIZE=5, RELOAD_TICKS=6; bin_x=6, bin_y=9.
1. Single, reset then press left at cycle 0 and hold 20 cycles -> exactly one shot, at cycle 1, with shoot_x=60, shoot_y=390, ammo=4; busy for 4 cycles. bin_y=50 on a re-press -> shoot_y=492 (wrap).
2. Burst, press left for 1 cycle at cycle 0 -> shots at cycles 1, 3, 5; ammo goes 5->2; busy until cycle 9; then idle.
3. Auto, hold left from full -> shots at cycles 1, 6, 11, 16, 21; ammo reaches 0; then reloading=1 for 6 cycles; then ammo=5.
4. Burst with ammo=2 -> only 2 shots; ammo=0; then automatic reload.
5. ammo=3 in S_IDLE, left rise and button_right in the same cycle -> no shot; reloading=1; after 6 cycles ammo=5.
6. reset_n pulled low mid-reload and mid-burst -> immediately ammo=5, reloading=0, busy=0, shot=0, with no clock edge; remaining burst shots are not issued.
